// File: rtl/fspan_pkg.sv
// fspan_pkg: shared definitions for the span/rectangle fill generator.
//   - FSM state encoding (IDLE / INIT / DRAW)
//   - lanes_log2(): log2 of the lane count, used to build the alignment mask
//   - smax()/smin(): signed max/min on a 32-bit carrier; callers sign-extend
//     their CORDW-wide operands in and truncate the result back out.
package fspan_pkg;

    localparam int STATEW = 2;
    localparam logic [STATEW-1:0] ST_IDLE = 2'd0;
    localparam logic [STATEW-1:0] ST_INIT = 2'd1;
    localparam logic [STATEW-1:0] ST_DRAW = 2'd2;

    typedef enum logic [STATEW-1:0] {
        IDLE = ST_IDLE,
        INIT = ST_INIT,
        DRAW = ST_DRAW
    } state_e;

    localparam int FUNCW = 32;

    function automatic int lanes_log2(input int lanes);
        int r;
        r = 0;
        for (int i = 0; i < 5; i++) begin
            if ((32'sd1 <<< i) < lanes) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    function automatic logic signed [FUNCW-1:0] smax(input logic signed [FUNCW-1:0] a,
                                                     input logic signed [FUNCW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [FUNCW-1:0] smin(input logic signed [FUNCW-1:0] a,
                                                     input logic signed [FUNCW-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/fspan_if.sv
// fspan_if: command + pixel-beat bundle of the fill generator.
//   master (command decoder / framebuffer side): drives start, oe, corners, clip
//   slave  (fspan): drives x, y, mask, valid, busy, done
interface fspan_if #(
    parameter int CORDW = 16,
    parameter int LANES = 4
);
    logic                    start;
    logic                    oe;
    logic signed [CORDW-1:0] x0;
    logic signed [CORDW-1:0] y0;
    logic signed [CORDW-1:0] x1;
    logic signed [CORDW-1:0] y1;
    logic signed [CORDW-1:0] clip_x0;
    logic signed [CORDW-1:0] clip_y0;
    logic signed [CORDW-1:0] clip_x1;
    logic signed [CORDW-1:0] clip_y1;
    logic signed [CORDW-1:0] x;
    logic signed [CORDW-1:0] y;
    logic [LANES-1:0]        mask;
    logic                    valid;
    logic                    busy;
    logic                    done;

    modport master (
        output start, oe, x0, y0, x1, y1, clip_x0, clip_y0, clip_x1, clip_y1,
        input  x, y, mask, valid, busy, done
    );

    modport slave (
        input  start, oe, x0, y0, x1, y1, clip_x0, clip_y0, clip_x1, clip_y1,
        output x, y, mask, valid, busy, done
    );
endinterface

// File: rtl/fspan_mask.sv
// fspan_mask: combinational lane-mask generator.
//   x    : group base (signed)
//   xl,xr: inclusive horizontal bounds (signed)
//   mask : bit i set when x+i lies within [xl, xr]
// Lane positions are formed one bit wider than CORDW so x+i cannot wrap.
module fspan_mask #(
    parameter int CORDW = 16,
    parameter int LANES = 4
) (
    input  logic signed [CORDW-1:0] x,
    input  logic signed [CORDW-1:0] xl,
    input  logic signed [CORDW-1:0] xr,
    output logic [LANES-1:0]        mask
);
    logic signed [CORDW:0] x_ext_s;
    logic signed [CORDW:0] xl_ext_s;
    logic signed [CORDW:0] xr_ext_s;

    assign x_ext_s  = $signed({x[CORDW-1], x});
    assign xl_ext_s = $signed({xl[CORDW-1], xl});
    assign xr_ext_s = $signed({xr[CORDW-1], xr});

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [CORDW:0] lane_s;
        assign lane_s  = x_ext_s + $signed((CORDW+1)'(i));
        assign mask[i] = (lane_s >= xl_ext_s) && (lane_s <= xr_ext_s);
    end
endmodule

// File: rtl/fspan.sv
// fspan: span/rectangle fill generator emitting LANES-pixel aligned groups.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.slave  : start/oe/corners/clip in; x/y/mask/valid/busy/done out
// Flow: IDLE latches normalised corners and clip window on start, INIT clips
// them (empty result finishes immediately), DRAW walks aligned groups row by
// row, advancing only on accepted beats (oe high).
module fspan
    import fspan_pkg::*;
#(
    parameter int CORDW = 16,
    parameter int LANES = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    fspan_if.slave bus
);
    localparam int LANES_LOG2 = lanes_log2(LANES);
    localparam logic [CORDW-1:0] ALIGN_MASK =
        ~CORDW'((32'd1 << LANES_LOG2) - 32'd1);
    localparam logic signed [CORDW-1:0] ONE  = CORDW'(1);
    localparam logic signed [CORDW-1:0] STEP = CORDW'(LANES);
    localparam logic signed [CORDW:0]   LAST_OFS = (CORDW+1)'(LANES - 1);
    localparam logic signed [CORDW-1:0] ZERO = {CORDW{1'b0}};

    // Clear low lane-index bits; on two's complement this floors toward -inf.
    function automatic logic signed [CORDW-1:0] align(input logic signed [CORDW-1:0] v);
        return v & ALIGN_MASK;
    endfunction

    function automatic logic signed [CORDW-1:0] cmax(input logic signed [CORDW-1:0] a,
                                                     input logic signed [CORDW-1:0] b);
        return CORDW'(smax(FUNCW'(a), FUNCW'(b)));
    endfunction

    function automatic logic signed [CORDW-1:0] cmin(input logic signed [CORDW-1:0] a,
                                                     input logic signed [CORDW-1:0] b);
        return CORDW'(smin(FUNCW'(a), FUNCW'(b)));
    endfunction

    state_e                  state_q, state_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic signed [CORDW-1:0] x_q, x_d;
    logic signed [CORDW-1:0] y_q, y_d;
    logic [LANES-1:0]        mask_q, mask_d;
    // xl/xr/yt/yb first hold the normalised corners, then the clipped bounds.
    logic signed [CORDW-1:0] xl_q, xl_d;
    logic signed [CORDW-1:0] xr_q, xr_d;
    logic signed [CORDW-1:0] yt_q, yt_d;
    logic signed [CORDW-1:0] yb_q, yb_d;
    logic signed [CORDW-1:0] cx0_q, cx0_d;
    logic signed [CORDW-1:0] cx1_q, cx1_d;
    logic signed [CORDW-1:0] cy0_q, cy0_d;
    logic signed [CORDW-1:0] cy1_q, cy1_d;

    logic signed [CORDW:0]   grp_end_s;
    logic                    last_col_s;
    logic [LANES-1:0]        lane_mask_s;

    // Group reaches the right edge when its last lane is at or past xr.
    assign grp_end_s  = $signed({x_q[CORDW-1], x_q}) + LAST_OFS;
    assign last_col_s = grp_end_s >= $signed({xr_q[CORDW-1], xr_q});

    // Mask is evaluated on next-cycle x and bounds so it can be registered.
    fspan_mask #(.CORDW(CORDW), .LANES(LANES)) u_mask (
        .x    (x_d),
        .xl   (xl_d),
        .xr   (xr_d),
        .mask (lane_mask_s)
    );

    assign mask_d = (state_d == DRAW) ? lane_mask_s : {LANES{1'b0}};

    // Next-state and datapath update for the IDLE/INIT/DRAW controller.
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        x_d     = x_q;
        y_d     = y_q;
        xl_d    = xl_q;
        xr_d    = xr_q;
        yt_d    = yt_q;
        yb_d    = yb_q;
        cx0_d   = cx0_q;
        cx1_d   = cx1_q;
        cy0_d   = cy0_q;
        cy1_d   = cy1_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    xl_d    = cmin(bus.x0, bus.x1);
                    xr_d    = cmax(bus.x0, bus.x1);
                    yt_d    = cmin(bus.y0, bus.y1);
                    yb_d    = cmax(bus.y0, bus.y1);
                    cx0_d   = bus.clip_x0;
                    cx1_d   = bus.clip_x1;
                    cy0_d   = bus.clip_y0;
                    cy1_d   = bus.clip_y1;
                    state_d = INIT;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            INIT: begin
                xl_d = cmax(xl_q, cx0_q);
                xr_d = cmin(xr_q, cx1_q);
                yt_d = cmax(yt_q, cy0_q);
                yb_d = cmin(yb_q, cy1_q);
                if ((xl_d > xr_d) || (yt_d > yb_d)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = DRAW;
                    x_d     = align(xl_d);
                    y_d     = yt_d;
                end
            end
            DRAW: begin
                if (bus.oe) begin
                    if (last_col_s && (y_q == yb_q)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (last_col_s) begin
                        y_d = y_q + ONE;
                        x_d = align(xl_q);
                    end else begin
                        x_d = x_q + STEP;
                    end
                end else begin
                    state_d = DRAW;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            x_q     <= ZERO;
            y_q     <= ZERO;
            mask_q  <= {LANES{1'b0}};
            xl_q    <= ZERO;
            xr_q    <= ZERO;
            yt_q    <= ZERO;
            yb_q    <= ZERO;
            cx0_q   <= ZERO;
            cx1_q   <= ZERO;
            cy0_q   <= ZERO;
            cy1_q   <= ZERO;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mask_q  <= mask_d;
            xl_q    <= xl_d;
            xr_q    <= xr_d;
            yt_q    <= yt_d;
            yb_q    <= yb_d;
            cx0_q   <= cx0_d;
            cx1_q   <= cx1_d;
            cy0_q   <= cy0_d;
            cy1_q   <= cy1_d;
        end
    end

    assign bus.x     = x_q;
    assign bus.y     = y_q;
    assign bus.mask  = mask_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.valid = (state_q == DRAW) && bus.oe;

endmodule

// File: tb/tb_fspan.sv
// tb_fspan: directed self-checking bench for fspan (CORDW=16, LANES=4).
module tb_fspan;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    fspan_if #(.CORDW(16), .LANES(4)) bus ();

    fspan #(.CORDW(16), .LANES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_start(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int cx0, input int cy0, input int cx1, input int cy1);
        @(posedge clk);
        #1;
        bus.x0      = 16'(ax0);
        bus.y0      = 16'(ay0);
        bus.x1      = 16'(ax1);
        bus.y1      = 16'(ay1);
        bus.clip_x0 = 16'(cx0);
        bus.clip_y0 = 16'(cy0);
        bus.clip_x1 = 16'(cx1);
        bus.clip_y1 = 16'(cy1);
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
    endtask

    // Wait (bounded) for the next valid beat at a falling edge and check it.
    task automatic wait_beat(input string tag, input int ex, input int ey, input int em);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge clk);
            if (bus.valid === 1'b1) seen = 1'b1;
        end
        check({tag, "_seen"}, 32'(seen), 32'sd1);
        if (seen) begin
            check({tag, "_x"}, 32'(bus.x), 32'(ex));
            check({tag, "_y"}, 32'(bus.y), 32'(ey));
            check({tag, "_mask"}, 32'(bus.mask), 32'(em));
        end
    endtask

    // The falling edge right after the last beat must show the done pulse.
    task automatic expect_done(input string tag);
        @(negedge clk);
        check({tag, "_done"}, 32'(bus.done), 32'sd1);
        check({tag, "_busy"}, 32'(bus.busy), 32'sd0);
        check({tag, "_valid"}, 32'(bus.valid), 32'sd0);
        @(negedge clk);
        check({tag, "_done_off"}, 32'(bus.done), 32'sd0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.oe    = 1'b1;
        bus.x0 = 16'sd0; bus.y0 = 16'sd0; bus.x1 = 16'sd0; bus.y1 = 16'sd0;
        bus.clip_x0 = 16'sd0; bus.clip_y0 = 16'sd0;
        bus.clip_x1 = 16'sd0; bus.clip_y1 = 16'sd0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'sd0);
        check("rst_done", 32'(bus.done), 32'sd0);
        check("rst_valid", 32'(bus.valid), 32'sd0);
        check("rst_x", 32'(bus.x), 32'sd0);
        check("rst_y", 32'(bus.y), 32'sd0);
        check("rst_mask", 32'(bus.mask), 32'sd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: span 2..5 on row 3, corners reversed
        do_start(5, 3, 2, 3, -32768, -32768, 32767, 32767);
        @(negedge clk);
        check("t1_init_valid", 32'(bus.valid), 32'sd0);
        check("t1_init_busy", 32'(bus.busy), 32'sd1);
        wait_beat("t1_b0", 0, 3, 12);
        wait_beat("t1_b1", 4, 3, 3);
        expect_done("t1");

        // 2: rectangle x 1..6, y 10..11
        do_start(1, 10, 6, 11, -32768, -32768, 32767, 32767);
        wait_beat("t2_b0", 0, 10, 14);
        wait_beat("t2_b1", 4, 10, 7);
        wait_beat("t2_b2", 0, 11, 14);
        wait_beat("t2_b3", 4, 11, 7);
        expect_done("t2");

        // 3a: clip x -10..20 to 0..7
        do_start(-10, 0, 20, 0, 0, -32768, 7, 32767);
        wait_beat("t3a_b0", 0, 0, 15);
        wait_beat("t3a_b1", 4, 0, 15);
        expect_done("t3a");

        // 3b: negative span -3..-1 aligns down to -4
        do_start(-3, 0, -1, 0, -32768, -32768, 32767, 32767);
        wait_beat("t3b_b0", -4, 0, 14);
        expect_done("t3b");

        // 4: empty after clip
        do_start(10, 0, 12, 0, -32768, -32768, 7, 32767);
        @(negedge clk);
        check("t4_init_busy", 32'(bus.busy), 32'sd1);
        check("t4_init_valid", 32'(bus.valid), 32'sd0);
        check("t4_init_done", 32'(bus.done), 32'sd0);
        expect_done("t4");

        // 5: backpressure mid-row plus an ignored start while busy
        do_start(1, 10, 6, 11, -32768, -32768, 32767, 32767);
        wait_beat("t5_b0", 0, 10, 14);
        @(posedge clk);
        #1;
        bus.oe    = 1'b0;
        bus.start = 1'b1;
        bus.x0    = 16'sd100;
        bus.y0    = 16'sd50;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_stall_valid", 32'(bus.valid), 32'sd0);
            check("t5_stall_x", 32'(bus.x), 32'sd4);
            check("t5_stall_y", 32'(bus.y), 32'sd10);
            check("t5_stall_mask", 32'(bus.mask), 32'sd7);
            @(posedge clk);
            #1;
        end
        bus.oe    = 1'b1;
        bus.start = 1'b0;
        wait_beat("t5_b1", 4, 10, 7);
        wait_beat("t5_b2", 0, 11, 14);
        wait_beat("t5_b3", 4, 11, 7);
        expect_done("t5");

        // 6: asynchronous reset mid-rectangle, then span repeated
        do_start(1, 10, 6, 11, -32768, -32768, 32767, 32767);
        wait_beat("t6_b0", 0, 10, 14);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 32'(bus.busy), 32'sd0);
        check("t6_rst_valid", 32'(bus.valid), 32'sd0);
        check("t6_rst_done", 32'(bus.done), 32'sd0);
        check("t6_rst_mask", 32'(bus.mask), 32'sd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_post_done", 32'(bus.done), 32'sd0);
            check("t6_post_busy", 32'(bus.busy), 32'sd0);
        end
        do_start(5, 3, 2, 3, -32768, -32768, 32767, 32767);
        wait_beat("t6_b0r", 0, 3, 12);
        wait_beat("t6_b1r", 4, 3, 3);
        expect_done("t6r");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/fspan.md
Name: fspan

Overview:
- Span/rectangle fill generator; the next generation of the single-lane horizontal line filler.
- Emits LANES-pixel aligned groups with a per-lane write mask, so a framebuffer writer can store several pixels per beat.
- Iterates over a rectangle (a span is simply y0 == y1) and clips to a viewport latched at start.
- Sits between the graphics command decoder and the framebuffer write port.

Parameters:
- CORDW, 16, signed coordinate width (bits).
- LANES, 4, pixels per output beat. Power of two, 1..16. LANES=1 with a wide clip reproduces the old single-pixel behaviour.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  start request; sampled only in IDLE
- oe  in  1  output enable / downstream ready
- x0, y0  in  CORDW signed  corner 0
- x1, y1  in  CORDW signed  corner 1 (corner order is arbitrary)
- clip_x0, clip_y0  in  CORDW signed  clip window minimum (inclusive)
- clip_x1, clip_y1  in  CORDW signed  clip window maximum (inclusive)
- x  out  CORDW signed  aligned group base (multiple of LANES)
- y  out  CORDW signed  current row
- mask  out  LANES  bit i set = pixel x+i is inside the clipped rectangle
- valid  out  1  x/y/mask valid this cycle
- busy  out  1  request in progress
- done  out  1  completion pulse, one cycle

Behaviour:
- One clock. Reset is asynchronous and active-low on rst_n.
- While rst_n is low: state=IDLE; busy, done, x, y, mask = 0. valid is therefore 0.
- Reset mid-operation aborts at once: no done pulse, internal bounds discarded.
- States: IDLE, INIT, DRAW.
- valid is combinational: valid = (state==DRAW) && oe.
- IDLE:
  - done <= 0.
  - On start: latch normalised bounds xa=min(x0,x1), xb=max(x0,x1), ya, yb likewise, and the four clip inputs.
  - Then state <= INIT, busy <= 1.
  - start is ignored in INIT and DRAW.
- INIT (exactly one cycle):
  - Clipped bounds: xl=max(xa,clip_x0), xr=min(xb,clip_x1), yt=max(ya,clip_y0), yb'=min(yb,clip_y1).
  - If xl>xr or yt>yb': state <= IDLE, busy <= 0, done <= 1. No beat is emitted.
  - Else: state <= DRAW, x <= align(xl), y <= yt.
  - align(v) = v with the low log2(LANES) bits cleared. This is floor on two's complement, so -3 aligns to -4 when LANES=4.
- DRAW:
  - mask[i] = (x+i >= xl) && (x+i <= xr), computed from registered x and bounds.
  - With oe=0, x, y and mask hold and valid is 0.
  - With oe=1 (beat accepted):
    - If the group contains xr (x+LANES-1 >= xr) and y==yb': state <= IDLE, busy <= 0, done <= 1.
    - If the group contains xr and y != yb': y <= y+1, x <= align(xl).
    - Otherwise: x <= x+LANES.
- Latency: first valid at earliest on the second cycle after the start edge.
- done is high for one cycle, coincident with busy falling.
- Arithmetic: all compares signed, CORDW wide. x only advances to groups at or before align(xr), so x+LANES never overflows. Lane offsets x+i use CORDW+1 bits.
- Clip bounds are inclusive. Degenerate clip (clip_x0 > clip_x1) yields the empty case.
- Bounds never change between start and done; input changes after start have no effect.

Decomposition:
- Package fspan_pkg holds:
  - state localparams (IDLE/INIT/DRAW, STATEW=2);
  - LANES_LOG2 derivation function;
  - signed max/min functions.
- One sub-module: fspan_mask (combinational lane-mask generator; params CORDW, LANES; inputs x, xl, xr; output mask). Reusable by a future sprite blitter.

Test Plan (CORDW=16, LANES=4, clip window -32768..32767 unless stated):
1. Span: start with x0=5, x1=2, y0=y1=3, oe=1 -> beats (x=0,y=3,mask=1100), (4,3,0011). done pulses the cycle after the second beat; busy falls with it.
2. Rectangle: x 1..6, y 10..11 -> beats (0,10,1110), (4,10,0111), (0,11,1110), (4,11,0111), then one done pulse.
3. Clip and negatives: x -10..20, y 0..0, clip_x 0..7 -> beats (0,0,1111), (4,0,1111). Separately x0=-3, x1=-1, y=0 -> single beat (-4,0,1110).
4. Empty after clip: x 10..12, clip_x1=7 -> valid never asserted; busy high one cycle (INIT); done pulse on the second edge after start.
5. Backpressure: in test 2, hold oe=0 for 3 cycles mid-row -> x/y/mask stable and valid=0 during the stall, same beat sequence overall. A start pulse while busy is ignored.
6. Reset: drop rst_n asynchronously mid test 2 -> busy, valid and done go 0 immediately with no done pulse. After release, test 1 repeated gives identical output.
